// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bundle between the fetch unit (master)
// and the instruction memory (slave).
interface fetch_unit_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_gnt,
      input  imem_rvalid,
      input  imem_rdata
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_gnt,
      output imem_rvalid,
      output imem_rdata
   );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch front end: credit-limited in-order requests, a 2-entry
// {pc, instr} buffer and redirect handling that discards stale responses.
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic         clk,
   input  logic         rst,
   fetch_unit_if.master imem,
   input  logic         stallF,
   input  logic         redirect,
   input  logic [31:0]  redirect_pc,
   output logic [31:0]  instrF,
   output logic [31:0]  PCF,
   output logic [31:0]  PCplus4F,
   output logic         validF
);

   logic [31:0] fetch_pc_q, fetch_pc_d;
   logic [1:0]  cnt_q, cnt_d;
   logic [1:0]  outst_q, outst_d;
   logic [1:0]  disc_q, disc_d;
   logic        head_q, head_d;

   logic [31:0] buf_pc_q    [2];
   logic [31:0] buf_instr_q [2];

   logic [2:0]  credit_used;
   logic        grant;
   logic        push;
   logic        pop;
   logic        wr_slot;
   logic [31:0] resp_pc;
   logic [31:0] head_pc;

   always_comb begin
      credit_used   = {1'b0, outst_q} + {1'b0, cnt_q};
      imem.imem_req  = rst && (credit_used < 3'd2) && !redirect;
      imem.imem_addr = fetch_pc_q;
      grant         = imem.imem_req && imem.imem_gnt;
      push          = imem.imem_rvalid && (disc_q == 2'd0) && !redirect;
      validF        = (cnt_q != 2'd0) && !redirect;
      pop           = validF && !stallF;
      wr_slot       = head_q ^ cnt_q[0];
      // Once discards are exhausted every in-flight request is consecutive and
      // ends just below fetch_pc, so the oldest one sits outst_q words back.
      resp_pc       = fetch_pc_q - {28'd0, outst_q, 2'b00};
   end

   always_comb begin
      fetch_pc_d = fetch_pc_q;
      outst_d    = outst_q + {1'b0, grant} - {1'b0, imem.imem_rvalid};
      disc_d     = disc_q;
      cnt_d      = cnt_q + {1'b0, push} - {1'b0, pop};
      head_d     = pop ? ~head_q : head_q;

      if (grant)
         fetch_pc_d = fetch_pc_q + 32'd4;
      if (imem.imem_rvalid && (disc_q != 2'd0))
         disc_d = disc_q - 2'd1;

      // Redirect overrides everything; whatever is still in flight afterwards is stale.
      if (redirect) begin
         fetch_pc_d = redirect_pc & 32'hFFFF_FFFC;
         cnt_d      = 2'd0;
         head_d     = 1'b0;
         disc_d     = outst_d;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fetch_pc_q <= RESET_PC;
         cnt_q      <= 2'd0;
         outst_q    <= 2'd0;
         disc_q     <= 2'd0;
         head_q     <= 1'b0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         cnt_q      <= cnt_d;
         outst_q    <= outst_d;
         disc_q     <= disc_d;
         head_q     <= head_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         buf_pc_q[wr_slot]    <= resp_pc;
         buf_instr_q[wr_slot] <= imem.imem_rdata;
      end
   end

   always_comb begin
      head_pc  = buf_pc_q[head_q];
      PCF      = validF ? head_pc                 : 32'h0;
      PCplus4F = validF ? head_pc + 32'd4         : 32'h0;
      instrF   = validF ? buf_instr_q[head_q]     : 32'h0;
   end

   a_credit_bound: assert property (@(posedge clk) disable iff (!rst)
      credit_used <= 3'd2)
      else $error("fetch_unit: outstanding + buffered exceeds 2");

   a_no_stray_resp: assert property (@(posedge clk) disable iff (!rst)
      !(imem.imem_rvalid && (outst_q == 2'd0)))
      else $error("fetch_unit: response with no outstanding request");

   a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
      !(push && (cnt_q == 2'd2) && !pop))
      else $error("fetch_unit: response arrived with a full buffer");

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: two instances (RESET_PC 0 and FFFF_FFF8),
// a latency-programmable memory model and scoreboards of expected fetches.
module tb_fetch_unit;
   localparam logic [31:0] KEY = 32'hA5A5_0000;

   typedef struct { logic [31:0] addr; int due; } mreq_t;
   typedef struct { logic [31:0] pc; logic [31:0] instr; } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   // instance A
   logic        rst_n, stall_a, redir_a, gnt_a;
   logic [31:0] redir_pc_a, instr_a, pc_a, pc4_a;
   logic        v_a;
   int          lat_a;
   fetch_unit_if ifa ();

   // instance B
   logic        rstb_n, stall_b;
   logic [31:0] instr_b, pc_b, pc4_b;
   logic        v_b;
   fetch_unit_if ifb ();

   fetch_unit #(.RESET_PC(32'h0000_0000)) u_a (
      .clk(clk), .rst(rst_n), .imem(ifa),
      .stallF(stall_a), .redirect(redir_a), .redirect_pc(redir_pc_a),
      .instrF(instr_a), .PCF(pc_a), .PCplus4F(pc4_a), .validF(v_a)
   );

   fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) u_b (
      .clk(clk), .rst(rstb_n), .imem(ifb),
      .stallF(stall_b), .redirect(1'b0), .redirect_pc(32'h0),
      .instrF(instr_b), .PCF(pc_b), .PCplus4F(pc4_b), .validF(v_b)
   );

   always @(posedge clk) cyc <= cyc + 1;

   // memory A: in-order responses, each no earlier than lat_a cycles after grant
   mreq_t mq_a[$];
   assign ifa.imem_gnt = gnt_a;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mq_a.delete();
         ifa.imem_rvalid <= 1'b0;
         ifa.imem_rdata  <= 32'h0;
      end else begin
         if (ifa.imem_rvalid) void'(mq_a.pop_front());
         if (ifa.imem_req && ifa.imem_gnt) mq_a.push_back('{ifa.imem_addr, cyc + lat_a});
         if (mq_a.size() != 0 && mq_a[0].due <= cyc + 1) begin
            ifa.imem_rvalid <= 1'b1;
            ifa.imem_rdata  <= mq_a[0].addr ^ KEY;
         end else begin
            ifa.imem_rvalid <= 1'b0;
            ifa.imem_rdata  <= 32'h0;
         end
      end
   end

   // memory B: always grants, answers exactly one cycle later
   assign ifb.imem_gnt = 1'b1;
   always @(posedge clk or negedge rstb_n) begin
      if (!rstb_n) begin
         ifb.imem_rvalid <= 1'b0;
         ifb.imem_rdata  <= 32'h0;
      end else begin
         ifb.imem_rvalid <= ifb.imem_req && ifb.imem_gnt;
         ifb.imem_rdata  <= ifb.imem_addr ^ KEY;
      end
   end

   exp_t sb_a[$];
   exp_t sb_b[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %b want %b", tag, obs, exp);
      end
   endtask

   task automatic push_a(input logic [31:0] pc);
      sb_a.push_back('{pc, pc ^ KEY});
   endtask

   task automatic push_b(input logic [31:0] pc);
      sb_b.push_back('{pc, pc ^ KEY});
   endtask

   // Called at a negedge: scores any head consumed at the next posedge, then advances one cycle.
   task automatic tick();
      exp_t e;
      #1;
      if (v_a && !stall_a) begin
         total++;
         assert (sb_a.size() != 0) else begin
            bad++;
            $error("FAIL A_unexpected: got PCF %h want nothing", pc_a);
         end
         if (sb_a.size() != 0) begin
            e = sb_a.pop_front();
            chk("A_PCF", pc_a, e.pc);
            chk("A_instrF", instr_a, e.instr);
            chk("A_PCplus4F", pc4_a, e.pc + 32'd4);
         end
      end
      if (v_b && !stall_b) begin
         total++;
         assert (sb_b.size() != 0) else begin
            bad++;
            $error("FAIL B_unexpected: got PCF %h want nothing", pc_b);
         end
         if (sb_b.size() != 0) begin
            e = sb_b.pop_front();
            chk("B_PCF", pc_b, e.pc);
            chk("B_instrF", instr_b, e.instr);
            chk("B_PCplus4F", pc4_b, e.pc + 32'd4);
         end
      end
      @(posedge clk);
      @(negedge clk);
      if (sb_b.size() == 0) stall_b = 1'b1;
   endtask

   task automatic drain_a();
      for (int i = 0; i < 40; i++) begin
         if (sb_a.size() == 0) break;
         tick();
      end
      chk("A_drain_left", sb_a.size(), 0);
      stall_a = 1'b1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got no finish want finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n = 1'b0; rstb_n = 1'b0;
      stall_a = 1'b0; stall_b = 1'b0;
      redir_a = 1'b0; redir_pc_a = 32'h0;
      gnt_a = 1'b1; lat_a = 1;
      repeat (2) @(negedge clk);
      #1;
      chk1("rst_validF", v_a, 1'b0);
      chk("rst_PCF", pc_a, 32'h0);
      chk("rst_instrF", instr_a, 32'h0);
      chk("rst_PCplus4F", pc4_a, 32'h0);
      chk1("rst_req", ifa.imem_req, 1'b0);
      chk1("rst_validF_b", v_b, 1'b0);
      @(negedge clk);

      // reset release and streaming
      rst_n = 1'b1; rstb_n = 1'b1;
      for (int i = 0; i < 6; i++) push_a(32'(i * 4));
      push_b(32'hFFFF_FFF8); push_b(32'hFFFF_FFFC); push_b(32'h0000_0000);
      #1;
      chk1("rel_req", ifa.imem_req, 1'b1);
      chk("rel_addr", ifa.imem_addr, 32'h0);
      chk("rel_addr_b", ifb.imem_addr, 32'hFFFF_FFF8);
      tick();
      chk1("first_valid_early", v_a, 1'b0);
      tick();
      chk1("first_valid", v_a, 1'b1);
      chk("first_PCF", pc_a, 32'h0);

      // stall with head at 8
      for (int i = 0; i < 20; i++) begin
         if (v_a && pc_a == 32'h8) break;
         tick();
      end
      chk1("head8_found", v_a && (pc_a == 32'h8), 1'b1);
      stall_a = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("stall_PCF", pc_a, 32'h8);
         chk("stall_PCplus4F", pc4_a, 32'hC);
         chk("stall_instrF", instr_a, 32'h8 ^ KEY);
      end
      chk1("stall_req_low", ifa.imem_req, 1'b0);
      stall_a = 1'b0;
      tick();
      chk("unstall_PCF", pc_a, 32'hC);
      drain_a();

      // redirect with two outstanding requests
      lat_a = 3;
      redir_a = 1'b1; redir_pc_a = 32'h40;
      sb_a.delete();
      #1;
      chk1("redir_req_low", ifa.imem_req, 1'b0);
      chk1("redir_valid_low", v_a, 1'b0);
      tick();
      redir_a = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (ifa.imem_addr == 32'h48) break;
         tick();
      end
      chk("two_out_addr", ifa.imem_addr, 32'h48);
      chk1("two_out_req", ifa.imem_req, 1'b0);
      redir_a = 1'b1; redir_pc_a = 32'h0000_0103;
      for (int i = 0; i < 4; i++) push_a(32'h100 + 32'(i * 4));
      tick();
      redir_a = 1'b0;
      chk("redir_addr", ifa.imem_addr, 32'h100);
      chk1("redir_credit_held", ifa.imem_req, 1'b0);
      chk1("redir_next_valid", v_a, 1'b0);
      lat_a = 1;
      stall_a = 1'b0;
      drain_a();

      // redirect coincident with a live response while stalled
      repeat (4) tick();
      lat_a = 2;
      redir_a = 1'b1; redir_pc_a = 32'h200;
      tick();
      redir_a = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (ifa.imem_rvalid) break;
         tick();
      end
      chk1("live_rvalid", ifa.imem_rvalid, 1'b1);
      redir_a = 1'b1; redir_pc_a = 32'h300;
      for (int i = 0; i < 3; i++) push_a(32'h300 + 32'(i * 4));
      #1;
      chk1("coinc_valid_low", v_a, 1'b0);
      tick();
      redir_a = 1'b0;
      chk1("coinc_next_valid", v_a, 1'b0);
      chk("coinc_next_PCF", pc_a, 32'h0);
      lat_a = 1;
      stall_a = 1'b0;
      drain_a();

      // asynchronous reset with work in flight
      repeat (4) tick();
      lat_a = 3;
      redir_a = 1'b1; redir_pc_a = 32'h400;
      tick();
      redir_a = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (v_a) break;
         tick();
      end
      chk1("pre_rst_valid", v_a, 1'b1);
      chk("pre_rst_PCF", pc_a, 32'h400);
      rst_n = 1'b0;
      #1;
      chk1("arst_validF", v_a, 1'b0);
      chk("arst_PCF", pc_a, 32'h0);
      chk("arst_instrF", instr_a, 32'h0);
      chk("arst_PCplus4F", pc4_a, 32'h0);
      chk1("arst_req", ifa.imem_req, 1'b0);
      repeat (2) tick();
      rst_n = 1'b1;
      lat_a = 1;
      push_a(32'h0); push_a(32'h4); push_a(32'h8);
      #1;
      chk1("rerel_req", ifa.imem_req, 1'b1);
      chk("rerel_addr", ifa.imem_addr, 32'h0);
      stall_a = 1'b0;
      drain_a();

      chk("B_drain_left", sb_b.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
